// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline registers between the
// D/E, E/M and M/W stages of the MIPS32 core.
package pipe_pkg;

  localparam int unsigned PC_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0] pc_t;

  // PC visible in every pipeline register while the core is held in reset.
  localparam pc_t RESET_PC_DEFAULT  = 32'h0000_3000;

  // PC carried by a bubble when the stage does not keep the stalled PC.
  localparam pc_t BUBBLE_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset to a fixed value,
// and a synchronous clear that loads a caller-supplied value instead of d.
module pipe_reg #(
  parameter int unsigned         WIDTH     = 32,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] clear_value,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins immediately; otherwise clear beats normal capture at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (clear) begin
      q <= clear_value;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_pc_de.sv
// Decode->Execute PC register. A stall inserts a bubble into E; the bubble
// either keeps the D-stage PC (so EPC stays meaningful) or a fixed bubble PC.
module pipe_pc_de
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH            = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC         = WIDTH'(RESET_PC_DEFAULT),
  parameter bit               KEEP_PC_ON_STALL = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_PC        = WIDTH'(BUBBLE_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stopen,
  input  logic [WIDTH-1:0] PC_in,
  output logic [WIDTH-1:0] PC_out
);

  logic             bubble_clear;
  logic [WIDTH-1:0] bubble_value;

  // When the bubble keeps the PC, a stall captures exactly like a normal
  // cycle, so the clear path is only used when a fixed bubble PC is wanted.
  assign bubble_clear = KEEP_PC_ON_STALL ? 1'b0 : stopen;
  assign bubble_value = BUBBLE_PC;

  pipe_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .clear       (bubble_clear),
    .clear_value (bubble_value),
    .d           (PC_in),
    .q           (PC_out)
  );

endmodule

// File: tb/tb_pipe_pc_de.sv
// Self-checking bench for pipe_pc_de. Two instances share the inputs: one
// keeps the PC on a stall, the other loads the bubble PC. Expected values are
// queued when stimulus is driven and compared after the capturing edge.
module tb_pipe_pc_de;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] BUBBLE_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stopen;
  logic [31:0] pc_in;
  logic [31:0] pc_out_keep;
  logic [31:0] pc_out_bubble;

  int compare_count;
  int mismatch_count;

  logic [31:0] exp_keep_q[$];
  logic [31:0] exp_bubble_q[$];

  pipe_pc_de #(
    .WIDTH            (32),
    .RESET_PC         (RESET_PC),
    .KEEP_PC_ON_STALL (1'b1),
    .BUBBLE_PC        (BUBBLE_PC)
  ) dut_keep (
    .clk    (clk),
    .reset  (reset),
    .stopen (stopen),
    .PC_in  (pc_in),
    .PC_out (pc_out_keep)
  );

  pipe_pc_de #(
    .WIDTH            (32),
    .RESET_PC         (RESET_PC),
    .KEEP_PC_ON_STALL (1'b0),
    .BUBBLE_PC        (BUBBLE_PC)
  ) dut_bubble (
    .clk    (clk),
    .reset  (reset),
    .stopen (stopen),
    .PC_in  (pc_in),
    .PC_out (pc_out_bubble)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one D-stage PC with reset released, queue both expected outputs,
  // then compare after the capturing edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic stall, input string tag);
    @(negedge clk);
    pc_in  = pc;
    stopen = stall;
    exp_keep_q.push_back(pc);
    exp_bubble_q.push_back(stall ? BUBBLE_PC : pc);
    @(posedge clk);
    #1;
    if (exp_keep_q.size() == 0 || exp_bubble_q.size() == 0) begin
      compare_count++;
      mismatch_count++;
      $display("[TB] FAIL %s: scoreboard empty, got none expected one entry", tag);
    end else begin
      checkOutput({tag, "_keep"},   pc_out_keep,   exp_keep_q.pop_front());
      checkOutput({tag, "_bubble"}, pc_out_bubble, exp_bubble_q.pop_front());
    end
  endtask

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    reset  = 1'b1;
    stopen = 1'b0;
    pc_in  = 32'h0000_3004;

    // Reset takes effect without any clock edge (first posedge is at t=5).
    #1 reset = 1'b0;
    #1;
    checkOutput("reset_async_keep",   pc_out_keep,   RESET_PC);
    checkOutput("reset_async_bubble", pc_out_bubble, RESET_PC);

    // Clock edges are ignored while reset is held.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold_keep",   pc_out_keep,   RESET_PC);
    checkOutput("reset_hold_bubble", pc_out_bubble, RESET_PC);

    // Release reset and stream PCs through with no stall.
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(32'h0000_3000, 1'b0, "follow0");
    applyStimulus(32'h0000_3004, 1'b0, "follow1");
    applyStimulus(32'h0000_3008, 1'b0, "follow2");

    // Stall: one instance keeps the PC, the other loads the bubble PC.
    applyStimulus(32'h0000_300C, 1'b1, "stall");
    applyStimulus(32'h0000_3010, 1'b0, "unstall");

    // Reset asserted mid-cycle while holding 3010 is seen before the next edge.
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_keep",   pc_out_keep,   RESET_PC);
    checkOutput("midreset_bubble", pc_out_bubble, RESET_PC);

    // Reset and stall together: reset wins, across an edge as well.
    @(negedge clk);
    stopen = 1'b1;
    pc_in  = 32'h0000_3014;
    #1;
    checkOutput("reset_stall_keep",   pc_out_keep,   RESET_PC);
    checkOutput("reset_stall_bubble", pc_out_bubble, RESET_PC);
    @(posedge clk);
    #1;
    checkOutput("reset_stall_edge_keep",   pc_out_keep,   RESET_PC);
    checkOutput("reset_stall_edge_bubble", pc_out_bubble, RESET_PC);

    @(negedge clk);
    reset  = 1'b1;
    stopen = 1'b0;
    applyStimulus(32'hFFFF_FFFC, 1'b0, "allones");
    applyStimulus(32'hFFFF_FFFC, 1'b1, "allones_stall");
    applyStimulus(32'hA5A5_5A5A, 1'b0, "pattern");

    // Mixed random traffic with occasional stalls.
    for (int i = 0; i < 24; i++) begin
      applyStimulus($urandom, ($urandom_range(0, 2) == 0), "random");
    end

    compare_count++;
    if (exp_keep_q.size() != 0 || exp_bubble_q.size() != 0) begin
      mismatch_count++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0",
               exp_keep_q.size() + exp_bubble_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
